mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences every data-memory access of the MEM stage.
//  Issues a req/ack transaction to DMEM for loads and stores, and stalls the upstream pipeline while the access is outstanding.
//  Qualifies the MEM/WB register load: a bubble is inserted while waiting, and the instruction retires on completion.
//  Sits between the EX/MEM register, the DMEM port and the MEM/WB register.
// PARAMETERS
//  REG_WIDTH       `REG_WIDTH (32)  data/address width
//  TIMEOUT_CYCLES  16               max ACCESS cycles before abort (>=2)
//  CNT_WIDTH       32               stall performance counter width
// PORTS
//  clk               in   1          clock, rising edge
//  reset             in   1          synchronous, active-high reset
//  ex_mem_valid      in   1          EX/MEM holds a valid instruction
//  ex_mem_opcode     in   7          EX/MEM instruction opcode
//  ex_mem_alu_out    in   REG_WIDTH  effective address
//  ex_mem_dataB      in   REG_WIDTH  store data
//  dmem_ack          in   1          DMEM completes the current req
//  dmem_rdata        in   REG_WIDTH  DMEM read data, valid with ack
//  dmem_req          out  1          DMEM request (registered)
//  dmem_we           out  1          1=store, 0=load (registered)
//  dmem_addr         out  REG_WIDTH  request address (registered)
//  dmem_wdata        out  REG_WIDTH  request write data (registered)
//  mem_stall         out  1          hold PC, IF/ID, ID/EX, EX/MEM (comb)
//  mem_wb_valid      out  1          MEM/WB captures a retiring instr; 0 => bubble (comb)
//  load_data         out  REG_WIDTH  captured read data to MEM/WB (registered)
//  timeout_err       out  1          sticky access-timeout flag
//  stall_cycles      out  CNT_WIDTH  saturating count of mem_stall cycles
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, timeout_err, stall_cycles, and wait_cnt.
//  is_mem = ex_mem_valid & (opcode==7'b0000011 LOAD | opcode==7'b0100011 STORE).
//  FSM IDLE:
//   - is_mem: go ACCESS; dmem_req<=1; dmem_we<=STORE; latch addr/wdata; wait_cnt<=0.
//   - else stay in IDLE.
//  FSM ACCESS:
//   - dmem_req, we, addr and wdata are held stable until the transaction ends.
//   - dmem_ack: req<=0; load_data<=dmem_rdata (loads only; stores leave it unchanged); go DONE, ok=1.
//   - else if wait_cnt==TIMEOUT_CYCLES-1: req<=0; timeout_err<=1; go DONE, ok=0.
//   - else wait_cnt+1.
//   - ack and timeout in the same cycle: ack wins.
//  FSM DONE: one cycle, then IDLE. Back-to-back memory ops re-enter ACCESS from IDLE next cycle.
//  mem_stall = (state==ACCESS) | (state==IDLE & is_mem).
//  mem_wb_valid:
//   - IDLE & ex_mem_valid & ~is_mem: 1 (non-memory ops: zero added latency).
//   - DONE & ok: 1.
//   - Otherwise 0 (bubble). An aborted access retires as a bubble.
//  Latency: a memory op with ack on ACCESS cycle k (k>=1) retires k+2 cycles after entering EX/MEM.
//  dmem_ack outside ACCESS is ignored.
//  dmem_rdata is sampled only on the ack cycle.
//  stall_cycles +1 each cycle mem_stall=1; saturates at all-ones.
//  timeout_err clears only on reset.
//  Reset mid-access: dmem_req drops at that edge; no retire; the FSM restarts in IDLE.
// TESTING
//  1. ALU op, ex_mem_valid=1, opcode=0110011 -> mem_wb_valid=1 same cycle; mem_stall=0; dmem_req stays 0.
//  2. LOAD addr=0x100; ack after 3 ACCESS cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles, load_data=0xDEADBEEF, mem_wb_valid=1 in DONE, stall_cycles=4.
//  3. STORE addr=0x40, dataB=0x55; ack on first ACCESS cycle -> dmem_we=1, dmem_wdata=0x55; load_data unchanged; retire 1 cycle later.
//  4. LOAD, no ack for 16 cycles -> req drops after the 16th cycle; timeout_err=1 (sticky); DONE has mem_wb_valid=0.
//  5. Ack coincident with the final timeout cycle -> treated as success; timeout_err stays 0.
//  6. reset=1 during ACCESS -> next cycle req=0, state IDLE, all outputs 0; a stray ack afterwards is ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack DMEM transaction per load/store,
// stalls upstream while it is outstanding and qualifies the MEM/WB load.
module mem_access_ctrl #(
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_mem_valid,
    input  logic [6:0]           ex_mem_opcode,
    input  logic [REG_WIDTH-1:0] ex_mem_alu_out,
    input  logic [REG_WIDTH-1:0] ex_mem_dataB,
    input  logic                 dmem_ack,
    input  logic [REG_WIDTH-1:0] dmem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [REG_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0] dmem_wdata,
    output logic                 mem_stall,
    output logic                 mem_wb_valid,
    output logic [REG_WIDTH-1:0] load_data,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    // state  | meaning
    // IDLE   | no access in flight; non-memory ops retire with zero added latency
    // ACCESS | dmem_req held high, waiting for ack or timeout
    // DONE   | one-cycle completion; retires the op only if it was acked
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         WAIT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ok;
    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              timed_out;

    assign is_load   = ex_mem_valid && (ex_mem_opcode == OP_LOAD);
    assign is_store  = ex_mem_valid && (ex_mem_opcode == OP_STORE);
    assign is_mem    = is_load || is_store;
    assign timed_out = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem_stall    = 1'b0;
        mem_wb_valid = 1'b0;
        case (state)
            IDLE: begin
                mem_stall    = is_mem;
                mem_wb_valid = ex_mem_valid && !is_mem;
                if (is_mem) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (dmem_ack || timed_out) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_wb_valid = ok;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            load_data   <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            ok          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= ex_mem_alu_out;
                        dmem_wdata <= ex_mem_dataB;
                        wait_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    // ack takes priority over a coincident timeout
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        ok       <= 1'b1;
                        if (!dmem_we) begin
                            load_data <= dmem_rdata;
                        end
                    end else if (timed_out) begin
                        dmem_req    <= 1'b0;
                        ok          <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (mem_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
